// File: rtl/inst_block_memory.sv
// Word-organised instruction memory returning one block of WORDS_PER_BLOCK words
// per read request after READ_LATENCY cycles; a load port writes single words while idle.
module inst_block_memory #(
    parameter int    WORD_WIDTH      = 32,
    parameter int    WORDS_PER_BLOCK = 4,
    parameter int    ADDR_WIDTH      = 6,
    parameter int    DEPTH_WORDS     = 256,
    parameter int    READ_LATENCY    = 5,
    parameter string INIT_FILE       = ""
) (
    input  logic                                  clock,
    input  logic                                  reset,
    input  logic                                  read,
    input  logic [ADDR_WIDTH-1:0]                 address,
    output logic [WORDS_PER_BLOCK*WORD_WIDTH-1:0] readinst,
    output logic                                  busywait,
    output logic                                  readvalid,
    input  logic                                  load_en,
    input  logic [$clog2(DEPTH_WORDS)-1:0]        load_addr,
    input  logic [WORD_WIDTH-1:0]                 load_data,
    output logic                                  load_ready
);

    localparam int LOAD_AW = $clog2(DEPTH_WORDS);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t                                 state;
    state_t                                 state_nxt;
    logic                                   accept;
    logic                                   done;
    logic [7:0]                             counter;
    logic [ADDR_WIDTH-1:0]                  addr_q;
    logic [WORDS_PER_BLOCK*WORD_WIDTH-1:0]  block_data;
    logic [WORD_WIDTH-1:0]                  mem [DEPTH_WORDS];

    // Power-up contents: all zero.
    initial begin
        for (int i = 0; i < DEPTH_WORDS; i++) mem[i] = '0;
    end

    assign load_ready = (state == IDLE);
    assign busywait   = (state == BUSY);

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE: begin
                if (read) begin
                    accept    = 1'b1;
                    state_nxt = BUSY;
                end
            end
            BUSY: begin
                if (counter == 8'd0) begin
                    done      = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            counter   <= 8'd0;
            readvalid <= 1'b0;
            readinst  <= '0;
        end else begin
            readvalid <= done;
            if (accept) begin
                counter <= 8'(READ_LATENCY - 1);
                addr_q  <= address;
            end else if (state == BUSY && counter != 8'd0) begin
                counter <= counter - 8'd1;
            end
            // Sampled at completion so a load on the accept edge is visible.
            if (done) readinst <= block_data;
        end
    end

    // Power-of-2 depth makes truncation of the word index the wrap-around.
    for (genvar g = 0; g < WORDS_PER_BLOCK; g++) begin : g_blk
        logic [LOAD_AW-1:0] idx;
        assign idx = LOAD_AW'(32'(addr_q) * WORDS_PER_BLOCK + g);
        assign block_data[g*WORD_WIDTH +: WORD_WIDTH] = mem[idx];
    end

    always @(posedge clock) begin
        if (!reset && load_en && state == IDLE) mem[load_addr] <= load_data;
    end

endmodule

// File: tb/tb_inst_block_memory.sv
// Directed bench for inst_block_memory: two instances (4-word/latency-5 and
// 8-word/latency-1) checked against a reference memory model and a block scoreboard.
module tb_inst_block_memory;

    logic         clock = 1'b0;
    logic         reset;

    logic         read_a, busywait_a, readvalid_a, load_en_a, load_ready_a;
    logic [5:0]   address_a;
    logic [127:0] readinst_a;
    logic [7:0]   load_addr_a;
    logic [31:0]  load_data_a;

    logic         read_b, busywait_b, readvalid_b, load_en_b, load_ready_b;
    logic [5:0]   address_b;
    logic [255:0] readinst_b;
    logic [7:0]   load_addr_b;
    logic [31:0]  load_data_b;

    logic [31:0]  model_a [256];
    logic [31:0]  model_b [256];
    logic [127:0] sb_a [$];
    logic [255:0] sb_b [$];

    int n_checks = 0;
    int n_pass   = 0;
    int pulses_a = 0;
    int pulses_b = 0;

    always #5 clock = ~clock;

    inst_block_memory #(.WORDS_PER_BLOCK(4), .READ_LATENCY(5)) dut_a (
        .clock(clock), .reset(reset), .read(read_a), .address(address_a),
        .readinst(readinst_a), .busywait(busywait_a), .readvalid(readvalid_a),
        .load_en(load_en_a), .load_addr(load_addr_a), .load_data(load_data_a),
        .load_ready(load_ready_a)
    );

    inst_block_memory #(.WORDS_PER_BLOCK(8), .READ_LATENCY(1)) dut_b (
        .clock(clock), .reset(reset), .read(read_b), .address(address_b),
        .readinst(readinst_b), .busywait(busywait_b), .readvalid(readvalid_b),
        .load_en(load_en_b), .load_addr(load_addr_b), .load_data(load_data_b),
        .load_ready(load_ready_b)
    );

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    function automatic logic [127:0] blk_a(input int addr);
        logic [127:0] r;
        for (int i = 0; i < 4; i++) r[i*32 +: 32] = model_a[(addr * 4 + i) % 256];
        return r;
    endfunction

    function automatic logic [255:0] blk_b(input int addr);
        logic [255:0] r;
        for (int i = 0; i < 8; i++) r[i*32 +: 32] = model_b[(addr * 8 + i) % 256];
        return r;
    endfunction

    // Scoreboard: every readvalid pulse pops one expected block.
    always @(negedge clock) begin
        if (readvalid_a) begin
            pulses_a++;
            chk("sb_a_pending", 256'(sb_a.size() > 0), 256'd1);
            if (sb_a.size() > 0) chk("readinst_a", 256'(readinst_a), 256'(sb_a.pop_front()));
        end
        if (readvalid_b) begin
            pulses_b++;
            chk("sb_b_pending", 256'(sb_b.size() > 0), 256'd1);
            if (sb_b.size() > 0) chk("readinst_b", readinst_b, sb_b.pop_front());
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    // All tasks below start and end right after a falling edge.
    task automatic load_a(input int addr, input logic [31:0] data);
        load_en_a = 1'b1; load_addr_a = 8'(addr); load_data_a = data;
        model_a[addr] = data;
        @(negedge clock);
        load_en_a = 1'b0;
    endtask

    task automatic load_b(input int addr, input logic [31:0] data);
        load_en_b = 1'b1; load_addr_b = 8'(addr); load_data_b = data;
        model_b[addr] = data;
        @(negedge clock);
        load_en_b = 1'b0;
    endtask

    task automatic wait_idle(input bit which_b);
        for (int n = 0; n < 300; n++) begin
            if (!(which_b ? busywait_b : busywait_a)) break;
            @(negedge clock);
        end
        chk(which_b ? "idle_timeout_b" : "idle_timeout_a",
            256'(which_b ? busywait_b : busywait_a), 256'd0);
        @(negedge clock);
    endtask

    task automatic rd_a(input int addr);
        read_a = 1'b1; address_a = 6'(addr);
        sb_a.push_back(blk_a(addr));
        @(negedge clock);
        read_a = 1'b0;
        wait_idle(1'b0);
    endtask

    task automatic rd_b(input int addr);
        read_b = 1'b1; address_b = 6'(addr);
        sb_b.push_back(blk_b(addr));
        @(negedge clock);
        read_b = 1'b0;
        wait_idle(1'b1);
    endtask

    initial begin
        int busy_cycles;
        int p0;
        int seq [6] = '{63, 5, 1, 9, 32, 17};

        for (int i = 0; i < 256; i++) begin
            model_a[i] = '0;
            model_b[i] = '0;
        end
        reset = 1'b1;
        read_a = 1'b0; address_a = '0; load_en_a = 1'b0; load_addr_a = '0; load_data_a = '0;
        read_b = 1'b0; address_b = '0; load_en_b = 1'b0; load_addr_b = '0; load_data_b = '0;
        @(negedge clock);
        @(negedge clock);
        chk("rst_busywait", 256'(busywait_a), 256'd0);
        chk("rst_readvalid", 256'(readvalid_a), 256'd0);
        chk("rst_readinst", 256'(readinst_a), 256'd0);
        chk("rst_load_ready", 256'(load_ready_a), 256'd1);
        reset = 1'b0;

        // Basic read of block 0 with latency 5
        load_a(0, 32'h0001_0003);
        load_a(1, 32'h0002_0002);
        load_a(2, 32'h0002_0118);
        load_a(3, 32'h0001_005A);
        read_a = 1'b1; address_a = 6'd0;
        sb_a.push_back(blk_a(0));
        @(negedge clock);
        read_a = 1'b0;
        busy_cycles = 0;
        for (int n = 0; n < 300 && busywait_a; n++) begin
            busy_cycles++;
            chk("busy_load_ready", 256'(load_ready_a), 256'd0);
            @(negedge clock);
        end
        chk("busy_cycles", 256'(busy_cycles), 256'd5);
        chk("block0_value", 256'(readinst_a),
            256'({32'h0001_005A, 32'h0002_0118, 32'h0002_0002, 32'h0001_0003}));
        @(negedge clock);
        chk("block0_hold", 256'(readinst_a),
            256'({32'h0001_005A, 32'h0002_0118, 32'h0002_0002, 32'h0001_0003}));

        // Address and read changes during BUSY are ignored
        for (int i = 4; i < 12; i++) load_a(i, 32'h4000_0000 + 32'(i * 16'h111));
        p0 = pulses_a;
        read_a = 1'b1; address_a = 6'd1;
        sb_a.push_back(blk_a(1));
        @(negedge clock);
        address_a = 6'd2;
        @(negedge clock);
        @(negedge clock);
        read_a = 1'b0;
        wait_idle(1'b0);
        @(negedge clock);
        chk("one_pulse_per_req", 256'(pulses_a), 256'(p0 + 1));

        // Top-of-memory block on both widths, and 8-word wrap to 0
        for (int i = 252; i < 256; i++) load_a(i, 32'hA000_0000 + 32'(i));
        rd_a(63);
        for (int i = 0; i < 16; i++) load_b(i, 32'hB000_0000 + 32'(i));
        for (int i = 248; i < 256; i++) load_b(i, 32'hB000_0000 + 32'(i));
        rd_b(63);
        chk("b63_word0", 256'(readinst_b[31:0]), 256'(32'hB000_00F8));
        rd_b(32);
        chk("b32_word7", 256'(readinst_b[255:224]), 256'(32'hB000_0007));

        // Load on the accept edge is seen by the read
        load_en_a = 1'b1; load_addr_a = 8'd4; load_data_a = 32'hDEAD_BEEF;
        model_a[4] = 32'hDEAD_BEEF;
        read_a = 1'b1; address_a = 6'd1;
        sb_a.push_back(blk_a(1));
        @(negedge clock);
        load_en_a = 1'b0; read_a = 1'b0;
        wait_idle(1'b0);
        chk("same_edge_word0", 256'(readinst_a[31:0]), 256'(32'hDEAD_BEEF));

        // Load while BUSY is dropped
        read_a = 1'b1; address_a = 6'd0;
        sb_a.push_back(blk_a(0));
        @(negedge clock);
        read_a = 1'b0;
        chk("busy_no_ready", 256'(load_ready_a), 256'd0);
        load_en_a = 1'b1; load_addr_a = 8'd5; load_data_a = 32'h1234_5678;
        @(negedge clock);
        load_en_a = 1'b0;
        wait_idle(1'b0);
        rd_a(1);
        chk("busy_load_dropped", 256'(readinst_a[63:32]), 256'(model_a[5]));

        // Reset two cycles into a read aborts it
        p0 = pulses_a;
        read_a = 1'b1; address_a = 6'd2;
        @(negedge clock);
        read_a = 1'b0;
        @(negedge clock);
        reset = 1'b1;
        load_en_a = 1'b1; load_addr_a = 8'd8; load_data_a = 32'hFFFF_0000;
        @(negedge clock);
        reset = 1'b0; load_en_a = 1'b0;
        chk("abort_busywait", 256'(busywait_a), 256'd0);
        chk("abort_readinst", 256'(readinst_a), 256'd0);
        for (int n = 0; n < 8; n++) @(negedge clock);
        chk("abort_no_pulse", 256'(pulses_a), 256'(p0));
        rd_a(2);
        chk("after_abort_word0", 256'(readinst_a[31:0]), 256'(32'h4000_0888));

        // Latency 1 with read held: accept and complete alternate
        p0 = pulses_b;
        read_b = 1'b1;
        for (int k = 0; k < 6; k++) begin
            address_b = 6'(seq[k]);
            if (k % 2 == 0) sb_b.push_back(blk_b(seq[k]));
            @(negedge clock);
            chk("held_readvalid_b", 256'(readvalid_b), 256'(k % 2 == 1));
        end
        read_b = 1'b0;
        @(negedge clock);
        @(negedge clock);
        chk("held_pulses_b", 256'(pulses_b), 256'(p0 + 3));

        chk("sb_a_drained", 256'(sb_a.size()), 256'd0);
        chk("sb_b_drained", 256'(sb_b.size()), 256'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
